// File: rtl/operand_pkg.sv
// Shared types for the operand-source selector: source indices, FSM states and the
// fallback source used for illegal selects.
package operand_pkg;

   typedef enum logic [1:0] {
      SRC_RF  = 2'd0,
      SRC_MEM = 2'd1,
      SRC_IMM = 2'd2
   } src_idx_e;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StWaitSrc = 2'd1,
      StHold    = 2'd2
   } op_sel_state_e;

   localparam src_idx_e DEFAULT_SRC = SRC_RF;

endpackage

// File: rtl/operand_wait_timer.sv
// Saturating wait counter: cleared on request accept, counts stalled cycles and flags the
// cycle on which the count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES == 0 never expires.
module operand_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CntMax)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Expire on the stalled cycle that takes the count to TIMEOUT_CYCLES.
   always_comb begin
      expire = 1'b0;
      if (TIMEOUT_CYCLES != 0) begin
         expire = enable && !clear && (count_q == CntMax - 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered, handshaked operand selector: latches a source index, waits for that source
// to report valid, captures its word and holds it on a valid/ready output to the ALU.
module operand_select_pipe
   import operand_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_SRC        = 3,
   parameter int unsigned SEL_BITS       = $clog2(NUM_SRC),
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [SEL_BITS-1:0]           req_sel,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_ack,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [SEL_BITS-1:0]           out_src,
   output logic                          err_bad_sel,
   output logic                          err_timeout
);

   op_sel_state_e state_q, state_d;

   logic [SEL_BITS-1:0]   sel_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [SEL_BITS-1:0]   out_src_q;
   logic                  out_valid_q;
   logic [NUM_SRC-1:0]    src_ack_q;
   logic                  err_bad_sel_q;
   logic                  err_timeout_q;

   logic                  accept;
   logic                  bad_sel;
   logic                  sel_vld;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  expire;
   logic                  timer_en;

   assign accept   = req_valid && req_ready;
   assign bad_sel  = (32'(req_sel) >= NUM_SRC);
   assign timer_en = (state_q == StWaitSrc) && !sel_vld;

   // Only the latched source is looked at; all other src_valid bits are ignored.
   always_comb begin
      sel_vld  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel_q == SEL_BITS'(i)) begin
            sel_vld  = src_valid[i];
            sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   operand_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accept),
      .enable (timer_en),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StWaitSrc;
         end
         StWaitSrc: begin
            if (sel_vld) begin
               state_d = StHold;
            end else if (expire) begin
               state_d = StIdle;
            end
         end
         StHold: begin
            if (out_ready) state_d = accept ? StWaitSrc : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // req_ready depends only on state and out_ready, never on the sources.
   always_comb begin
      req_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q         <= '0;
         out_data_q    <= '0;
         out_src_q     <= '0;
         out_valid_q   <= 1'b0;
         src_ack_q     <= '0;
         err_bad_sel_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         src_ack_q     <= '0;
         err_bad_sel_q <= 1'b0;
         err_timeout_q <= 1'b0;
         if (accept) begin
            sel_q         <= bad_sel ? SEL_BITS'(DEFAULT_SRC) : req_sel;
            err_bad_sel_q <= bad_sel;
         end
         if (state_q == StWaitSrc) begin
            if (sel_vld) begin
               out_data_q  <= sel_data;
               out_src_q   <= sel_q;
               out_valid_q <= 1'b1;
               src_ack_q   <= NUM_SRC'(1) << sel_q;
            end else if (expire) begin
               err_timeout_q <= 1'b1;
            end
         end
         if ((state_q == StHold) && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_data    = out_data_q;
   assign out_src     = out_src_q;
   assign out_valid   = out_valid_q;
   assign src_ack     = src_ack_q;
   assign err_bad_sel = err_bad_sel_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_operand_select_pipe.sv
// Directed bench for operand_select_pipe: latency, stalls, illegal select, timeout,
// hold stability, back-to-back requests and asynchronous reset.
module tb_operand_select_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_sel;
   logic [23:0] src_data;
   logic [2:0]  src_valid;
   logic [2:0]  src_ack;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        err_bad_sel;
   logic        err_timeout;

   int n_checks = 0;
   int n_errors = 0;
   int lat, to_at, bad_at;

   always #5 clk = ~clk;

   operand_select_pipe #(
      .DATA_WIDTH     (8),
      .NUM_SRC        (3),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_sel     (req_sel),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_ack     (src_ack),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_src     (out_src),
      .err_bad_sel (err_bad_sel),
      .err_timeout (err_timeout)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request from IDLE; src_valid takes vmask after edge valid_at (0 = never).
   // Returns edge counts (from the accept edge) of first out_valid / err_timeout / err_bad_sel.
   task automatic issue(input logic [1:0] sel, input logic [2:0] vmask, input int valid_at,
                        output int lat_o, output int to_o, output int bad_o);
      lat_o     = 0;
      to_o      = 0;
      bad_o     = 0;
      src_valid = 3'b000;
      req_valid = 1'b1;
      req_sel   = sel;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1) req_valid = 1'b0;
         if (c == valid_at) src_valid = vmask;
         if (err_timeout && to_o == 0) to_o = c;
         if (err_bad_sel && bad_o == 0) bad_o = c;
         if (out_valid) begin
            lat_o = c;
            break;
         end
         if (to_o != 0) break;
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      src_valid = 3'b000;
      check_eq("retire_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic quiet_after_reset(input string tag);
      int pulses = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (src_ack != 3'b000 || err_bad_sel || err_timeout || out_valid) pulses++;
      end
      check_eq(tag, 32'(pulses), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_sel   = 2'd0;
      src_data  = {8'hA5, 8'h3C, 8'h11};
      src_valid = 3'b000;
      out_ready = 1'b0;
      #12;
      check_eq("rst_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'd0);
      check_eq("rst_out_src", 32'(out_src), 32'd0);
      check_eq("rst_src_ack", 32'(src_ack), 32'd0);
      check_eq("rst_errs", {30'd0, err_bad_sel, err_timeout}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Zero-wait IMM select.
      issue(2'd2, 3'b100, 1, lat, to_at, bad_at);
      check_eq("imm_latency", 32'(lat), 32'd2);
      check_eq("imm_data", 32'(out_data), 32'hA5);
      check_eq("imm_src", 32'(out_src), 32'd2);
      check_eq("imm_ack", 32'(src_ack), 32'b100);
      check_eq("imm_req_ready_hold", 32'(req_ready), 32'd0);
      tick();
      check_eq("imm_ack_one_cycle", 32'(src_ack), 32'd0);
      check_eq("imm_still_valid", 32'(out_valid), 32'd1);
      retire();

      // MEM arrives 5 cycles late; RF/IMM valid must be ignored.
      issue(2'd1, 3'b010, 6, lat, to_at, bad_at);
      check_eq("mem_latency", 32'(lat), 32'd7);
      check_eq("mem_data", 32'(out_data), 32'h3C);
      check_eq("mem_src", 32'(out_src), 32'd1);
      check_eq("mem_ack", 32'(src_ack), 32'b010);
      check_eq("mem_no_timeout", 32'(to_at), 32'd0);
      retire();

      // Illegal select falls back to RF.
      issue(2'd3, 3'b001, 1, lat, to_at, bad_at);
      check_eq("bad_sel_pulse_at", 32'(bad_at), 32'd1);
      check_eq("bad_sel_latency", 32'(lat), 32'd2);
      check_eq("bad_sel_data", 32'(out_data), 32'h11);
      check_eq("bad_sel_src", 32'(out_src), 32'd0);
      check_eq("bad_sel_ack", 32'(src_ack), 32'b001);
      check_eq("bad_sel_once", 32'(err_bad_sel), 32'd0);

      // Hold stability while RF changes, then back-to-back request.
      src_data[7:0] = 8'h77;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("hold_stable_data", 32'(out_data), 32'h11);
         check_eq("hold_stable_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      req_valid = 1'b1;
      req_sel   = 2'd0;
      src_valid = 3'b001;
      #1;
      check_eq("b2b_req_ready", 32'(req_ready), 32'd1);
      tick();
      out_ready = 1'b0;
      req_valid = 1'b0;
      check_eq("b2b_retired", 32'(out_valid), 32'd0);
      tick();
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
      check_eq("b2b_data", 32'(out_data), 32'h77);
      retire();

      // MEM never valid: timeout 15 cycles after entering WAIT_SRC.
      issue(2'd1, 3'b000, 0, lat, to_at, bad_at);
      check_eq("to_pulse_at", 32'(to_at), 32'd16);
      check_eq("to_no_capture", 32'(lat), 32'd0);
      check_eq("to_out_valid", 32'(out_valid), 32'd0);
      check_eq("to_req_ready", 32'(req_ready), 32'd1);
      tick();
      check_eq("to_one_cycle", 32'(err_timeout), 32'd0);

      // Reset in the middle of WAIT_SRC.
      src_valid = 3'b000;
      req_valid = 1'b1;
      req_sel   = 2'd1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check_eq("wait_req_ready_busy", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      src_valid = 3'b010;
      #1;
      check_eq("rst_wait_req_ready", 32'(req_ready), 32'd1);
      check_eq("rst_wait_out_valid", 32'(out_valid), 32'd0);
      #3 rst_n = 1'b1;
      quiet_after_reset("rst_wait_quiet");

      // Reset in the middle of HOLD.
      issue(2'd2, 3'b100, 1, lat, to_at, bad_at);
      check_eq("pre_rst_hold_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_hold_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_hold_out_data", 32'(out_data), 32'd0);
      check_eq("rst_hold_out_src", 32'(out_src), 32'd0);
      check_eq("rst_hold_req_ready", 32'(req_ready), 32'd1);
      src_valid = 3'b000;
      #3 rst_n = 1'b1;
      quiet_after_reset("rst_hold_quiet");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/operand_select_pipe.md
Name: operand_select_pipe

Overview:
- Registered, handshaked operand-source selector for the datapath. It replaces a purely combinational RF/MEM/IMM mux.
- Selects one of NUM_SRC operand sources, such as register file, memory, immediate and forwarding paths.
- Waits for the chosen source to report valid data, which covers multi-cycle memory reads.
- Presents the operand to the ALU stage on a valid/ready output, with error reporting for illegal selects and stalled sources.

Parameters:
- DATA_WIDTH, 8, width of each operand word.
- NUM_SRC, 3, number of sources (minimum 2). Index 0 = RF, 1 = MEM, 2 = IMM, higher indices free.
- SEL_BITS, $clog2(NUM_SRC), select width. Derived; never overridden.
- TIMEOUT_CYCLES, 15, maximum wait for the selected source. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  select request present
- req_ready  output  1  block can accept a request
- req_sel  input  SEL_BITS  source index
- src_data  input  NUM_SRC*DATA_WIDTH  packed sources; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_valid  input  NUM_SRC  per-source data valid
- src_ack  output  NUM_SRC  one-hot, one-cycle pulse when the source's data is captured
- out_valid  output  1  operand valid
- out_ready  input  1  consumer accepts operand
- out_data  output  DATA_WIDTH  captured operand
- out_src  output  SEL_BITS  index that supplied out_data
- err_bad_sel  output  1  one-cycle pulse: illegal select
- err_timeout  output  1  one-cycle pulse: source wait expired

Behaviour:
- Reset (async assert, sync deassert at the next clk edge)
  - State IDLE.
  - req_ready=1.
  - out_valid=0, out_data=0, out_src=0.
  - src_ack=0, err_bad_sel=0, err_timeout=0.
  - Wait counter=0.
- FSM states: IDLE, WAIT_SRC, HOLD.
- req_ready = (state==IDLE) || (state==HOLD && out_ready). Handshake fires when req_valid && req_ready.
- Request accept (edge)
  - Latch sel_q = req_sel and clear the wait counter.
  - If req_sel >= NUM_SRC: sel_q = 0 (RF fallback, same as legacy default) and err_bad_sel pulses the following cycle.
  - Next state WAIT_SRC.
- WAIT_SRC
  - Each cycle, sample src_valid[sel_q].
  - If high: out_data <= src_data[sel_q], out_src <= sel_q, out_valid <= 1, src_ack[sel_q] pulses one cycle; next state HOLD.
  - Else: the counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: err_timeout pulses one cycle, nothing is captured, out_valid stays 0; next state IDLE.
  - A request is never accepted in WAIT_SRC.
- HOLD
  - out_valid=1; out_data and out_src stable until out_ready.
  - out_ready && req_valid: operand retires, new request latched, out_valid <= 0; next state WAIT_SRC. No bubble on the input side.
  - out_ready && !req_valid: out_valid <= 0; next state IDLE.
- Latency: request accepted at edge N, source valid at cycle N+1 → out_valid high at N+2. Minimum 2 cycles; each cycle src_valid stays low adds one.
- Combinational paths: none from src_* to out_*. req_ready depends combinationally on out_ready only.
- src_valid on non-selected sources is ignored; those sources never see src_ack.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It saturates and never wraps.
- Reset mid-WAIT_SRC or mid-HOLD: the operand is dropped with no ack or error pulse; outputs return to their reset values immediately.

Decomposition:
- Shared package operand_pkg holds:
  - enum src_idx_e {SRC_RF=0, SRC_MEM=1, SRC_IMM=2}
  - FSM state enum op_sel_state_e
  - localparam DEFAULT_SRC = SRC_RF
- One natural sub-module: operand_wait_timer (clear/enable/expire, parameter TIMEOUT_CYCLES). Everything else is a single module.

Test Plan:
- Reset, then 1-cycle req_sel=2 with src_valid=3'b100 and IMM=8'hA5 → out_valid at cycle +2, out_data=8'hA5, out_src=2, src_ack=3'b100 for one cycle.
- req_sel=1 with MEM valid delayed 5 cycles (data 8'h3C) → out_valid exactly 5 cycles later than the zero-wait case, data 8'h3C, no err_timeout.
- req_sel=3 with NUM_SRC=3 and RF=8'h11 → err_bad_sel pulses once; out_data=8'h11, out_src=0.
- req_sel=1 with MEM never valid, TIMEOUT_CYCLES=15 → err_timeout pulses 15 cycles after entering WAIT_SRC, out_valid stays 0, FSM returns to IDLE and req_ready=1.
- out_ready held low 4 cycles in HOLD while the RF input changes → out_data stable; back-to-back request with out_ready=1 is accepted in the same cycle, and the next operand appears 2 cycles later.
- rst_n asserted mid-WAIT_SRC and mid-HOLD → out_valid=0, req_ready=1 asynchronously, no src_ack or error pulses after release.
